// File: rtl/main_decoder_pkg.sv
// Shared widths, types and decode helpers for the registered 2-to-4 decoder.
package main_decoder_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned N_OUT = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_OUT-1:0] dec_t;

  // Bit i of the result corresponds to output yi.
  function automatic dec_t decode_onehot(input sel_t sel, input logic en);
    dec_t v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic is_onehot0(input dec_t v);
    return ((v & (v - dec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/main_decoder_if.sv
// Signal bundle for the decoder select/enable inputs and its four outputs.
// Optional err signal exists only when MAIN_DECODER_ONEHOT_CHK_EN is defined.
interface main_decoder_if;
  import main_decoder_pkg::*;

  sel_t w;
  logic en;
  logic y0;
  logic y1;
  logic y2;
  logic y3;
`ifdef MAIN_DECODER_ONEHOT_CHK_EN
  logic err;
`endif

  modport master (
    output w, en,
`ifdef MAIN_DECODER_ONEHOT_CHK_EN
    input  err,
`endif
    input  y0, y1, y2, y3
  );

  modport slave (
    input  w, en,
`ifdef MAIN_DECODER_ONEHOT_CHK_EN
    output err,
`endif
    output y0, y1, y2, y3
  );

endinterface

// File: rtl/main_decoder_core.sv
// Purely combinational 2-to-4 decode with enable; active-high one-hot result.
module main_decoder_core
  import main_decoder_pkg::*;
(
  input  sel_t i_sel,
  input  logic i_en,
  output dec_t o_dec
);

  assign o_dec = decode_onehot(i_sel, i_en);

endmodule

// File: rtl/main_decoder.sv
// Registered 2-to-4 decoder with enable, async active-high reset and selectable
// output polarity. Optional one-hot checker: define MAIN_DECODER_ONEHOT_CHK_EN.
module main_decoder
  import main_decoder_pkg::*;
#(
  parameter int OUT_ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic rst,
  input  sel_t w,
  input  logic en,
  output logic y0,
  output logic y1,
  output logic y2,
`ifdef MAIN_DECODER_ONEHOT_CHK_EN
  output logic err,
`endif
  output logic y3
);

  // Inactive level of the physical outputs; also the reset/disabled value.
  localparam dec_t INACTIVE = (OUT_ACTIVE_HIGH != 0) ? '0 : '1;

  dec_t w_dec;
  dec_t r_y;

  main_decoder_core u_core (
    .i_sel (w),
    .i_en  (en),
    .o_dec (w_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_y <= INACTIVE;
    else     r_y <= w_dec ^ INACTIVE;
  end

  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];

`ifdef MAIN_DECODER_ONEHOT_CHK_EN
  dec_t w_act;
  logic r_err;

  // Checks the registered outputs in active-high form, independent of polarity.
  assign w_act = r_y ^ INACTIVE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_err <= 1'b0;
    else if (!is_onehot0(w_act)) r_err <= 1'b1;
  end

  assign err = r_err;

  always_ff @(posedge clk) begin
    if (!rst) a_onehot0: assert (is_onehot0(w_act));
  end
`endif

endmodule

// File: tb/tb_main_decoder.sv
// Scoreboard bench for main_decoder: both output polarities driven in parallel.
module tb_main_decoder;
  import main_decoder_pkg::*;

  logic clk;
  logic rst;

  main_decoder_if bh ();
  main_decoder_if bl ();

  main_decoder #(.OUT_ACTIVE_HIGH(1)) dut_hi (
    .clk (clk),
    .rst (rst),
    .w   (bh.w),
    .en  (bh.en),
    .y0  (bh.y0),
    .y1  (bh.y1),
    .y2  (bh.y2),
`ifdef MAIN_DECODER_ONEHOT_CHK_EN
    .err (bh.err),
`endif
    .y3  (bh.y3)
  );

  main_decoder #(.OUT_ACTIVE_HIGH(0)) dut_lo (
    .clk (clk),
    .rst (rst),
    .w   (bl.w),
    .en  (bl.en),
    .y0  (bl.y0),
    .y1  (bl.y1),
    .y2  (bl.y2),
`ifdef MAIN_DECODER_ONEHOT_CHK_EN
    .err (bl.err),
`endif
    .y3  (bl.y3)
  );

  // Expected values packed as {y0,y1,y2,y3}.
  typedef struct {
    string      name;
    logic [3:0] hi;
    logic [3:0] lo;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: y0..y3=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after each rising edge, or an async-reset probe, compare the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check4({e.name, "_hi"}, {bh.y0, bh.y1, bh.y2, bh.y3}, e.hi);
        check4({e.name, "_lo"}, {bl.y0, bl.y1, bl.y2, bl.y3}, e.lo);
`ifdef MAIN_DECODER_ONEHOT_CHK_EN
        check1({e.name, "_err_hi"}, bh.err, 1'b0);
        check1({e.name, "_err_lo"}, bl.err, 1'b0);
`endif
      end
    end
  end

  task automatic drive(input logic r, input logic [1:0] sel, input logic e);
    rst   = r;
    bh.w  = sel;
    bl.w  = sel;
    bh.en = e;
    bl.en = e;
  endtask

  // Expectation applies to the rising edge following this negedge.
  task automatic step(input logic r, input logic [1:0] sel, input logic e,
                      input string name, input logic [3:0] hi, input logic [3:0] lo);
    exp_t x;
    @(negedge clk);
    drive(r, sel, e);
    x.name = name; x.hi = hi; x.lo = lo;
    q.push_back(x);
  endtask

  // Raise rst between edges and check the outputs before any clock edge.
  task automatic async_rst(input string name, input logic [3:0] hi, input logic [3:0] lo);
    exp_t x;
    @(negedge clk);
    #2;
    rst = 1'b1;
    x.name = name; x.hi = hi; x.lo = lo;
    q.push_back(x);
    -> chk_ev;
    #2;
  endtask

  initial begin
    drive(1'b0, 2'b10, 1'b1);
    repeat (2) @(posedge clk);

    step(1'b0, 2'b10, 1'b1, "pre_y2",     4'b0010, 4'b1101);
    async_rst("async_rst",                 4'b0000, 4'b1111);
    step(1'b1, 2'b10, 1'b1, "rst_hold",   4'b0000, 4'b1111);
    step(1'b0, 2'b00, 1'b0, "en0_w00",    4'b0000, 4'b1111);

    step(1'b0, 2'b00, 1'b1, "w00",        4'b1000, 4'b0111);
    step(1'b0, 2'b01, 1'b1, "w01",        4'b0100, 4'b1011);
    step(1'b0, 2'b10, 1'b1, "w10",        4'b0010, 4'b1101);
    step(1'b0, 2'b11, 1'b1, "w11",        4'b0001, 4'b1110);
    step(1'b0, 2'b11, 1'b1, "w11_hold",   4'b0001, 4'b1110);
    step(1'b0, 2'b11, 1'b0, "en_fall",    4'b0000, 4'b1111);
    step(1'b0, 2'b10, 1'b0, "en0_w10",    4'b0000, 4'b1111);
    step(1'b0, 2'b01, 1'b1, "en_rise",    4'b0100, 4'b1011);
    step(1'b0, 2'b10, 1'b1, "move_y2",    4'b0010, 4'b1101);

    async_rst("rst_from_y2",               4'b0000, 4'b1111);
    step(1'b0, 2'b10, 1'b1, "rel_y2",     4'b0010, 4'b1101);
    step(1'b0, 2'b00, 1'b1, "move_y0",    4'b1000, 4'b0111);
    step(1'b0, 2'b11, 1'b1, "jump_y3",    4'b0001, 4'b1110);
    step(1'b0, 2'b00, 1'b0, "final_off",  4'b0000, 4'b1111);

    for (int unsigned i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Registered 2-to-4 line decoder with active-high enable.
- Selects one of four one-hot outputs from a 2-bit select `w`.
- All outputs are forced low when `en`=0.
- Used as a small address/select decoder in control paths; outputs are flopped, so downstream logic sees glitch-free selects.

Parameters:
- OUT_ACTIVE_HIGH, default 1: output polarity.
  - 1: the selected output is 1 and all others are 0.
  - 0: every output is inverted, including the reset and disabled values (all 1s).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- w    input  2  select code; 00→y0, 01→y1, 10→y2, 11→y3
- en   input  1  decode enable; 0 forces all outputs inactive
- y0   output 1  registered decode of w==00
- y1   output 1  registered decode of w==01
- y2   output 1  registered decode of w==10
- y3   output 1  registered decode of w==11

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset:
  - rst=1 immediately clears y0..y3 to inactive, i.e. 0 when OUT_ACTIVE_HIGH=1, without waiting for a clock edge.
  - Outputs hold inactive while rst=1.
  - The first update happens on the first rising clk edge after rst deasserts.
- Decode function, evaluated on each rising clk edge with rst=0:
  - en=1: exactly the output indexed by w goes active; the other three go inactive.
  - en=0: all four outputs go inactive, regardless of w.
- Latency:
  - Exactly 1 clock from sampling (w, en) to the outputs.
  - Outputs are stable between edges.
  - No combinational path from inputs to outputs.
- Invariant: at any time at most one of y0..y3 is active, and exactly one is active iff the en sampled at the last edge was 1.
- Timing of changes:
  - A change on w while en=1 moves the active output on the next edge; there is no intermediate all-zero cycle.
  - en toggling 1→0 clears all outputs on the next edge.
  - en toggling 0→1 activates y[w] on the next edge.
- Reset mid-operation: asynchronous clear overrides any pending decode. No internal state other than the four output flops.
- X/Z on w or en: behaviour unspecified. The bench drives only known values.

Optional Feature:
- Macro MAIN_DECODER_ONEHOT_CHK_EN.
- Defined:
  - Adds output port `err` (1 bit, registered, reset 0).
  - `err` is set on a clock edge if the current registered outputs are neither all-inactive nor one-hot.
  - `err` is sticky until rst.
  - Also adds a simulation-only assertion with the same check.
- Undefined: no `err` port and no checking logic; the port list is exactly as above.

Decomposition:
- Package main_decoder_pkg holds:
  - SEL_W=2 and N_OUT=4.
  - A function returning the one-hot N_OUT vector for a given select and enable.
- One natural sub-module, main_decoder_core: purely combinational 2-to-4 decode with enable.
- The top-level main_decoder adds:
  - the output flops with asynchronous reset,
  - polarity handling,
  - the optional checker.

Test Plan:
- rst=1 pulse, asynchronous and mid-cycle, with en=1, w=10 → y0..y3=0000 immediately, without a clock edge.
- rst=0, en=0, w=00 for 1 clk → y0..y3=0000.
- en=1, then w=00, 01, 10, 11 on successive clks → one cycle after each: y0=1 (others 0), then y1=1, then y2=1, then y3=1.
- en=1, w=11 held, then en=0 → next edge all outputs 0; re-assert en=1 with w=01 → next edge y1=1 only.
- Assert rst while y2=1 → y2 drops to 0 asynchronously; after release with en=1, w=10 → y2=1 on the first edge.
- OUT_ACTIVE_HIGH=0: reset → 1111; en=1, w=01 → y0..y3=1011. With MAIN_DECODER_ONEHOT_CHK_EN defined, err stays 0 throughout every scenario above.
